bus_dest_regs: RTL and testbench

Destination side of the 32-bit CPU datapath bus: it takes the value driven onto `busOut` by the bus multiplexer and loads it into exactly one of 24 destination registers per clock, selected by one-hot `*in` strobes from the control unit. Its register outputs feed back as the bus-source inputs (`busR0in`…`busMDRin`). It also owns the PC increment path, the MDR memory-load path, and illegal multi-destination detection.

---
 rtl/bus_dest_regs_if.sv | 51 +++++
 rtl/bus_dest_regs.sv | 142 ++++++++++++++
 tb/tb_bus_dest_regs.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dest_regs_if.sv
// bus_dest_regs_if
// Groups the destination-side datapath signals of the 32-bit CPU bus.
//   master : control unit / bus mux side. Drives busIn, the 24 load strobes,
//            IncPC, Read and Mdatain. Receives the register contents and the
//            wr_ack / last_dest / dest_err status.
//   slave  : bus_dest_regs side, with the opposite directions.
// Destination index order: R0..R15 = 0..15, HI = 16, LO = 17, PC = 18,
// MDR = 19, Out_Port = 20, Y = 21, MAR = 22, IR = 23.
interface bus_dest_regs_if;
  logic [31:0] busIn;
  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic        HIin, LOin, PCin, MDRin, Out_Portin, Yin, MARin, IRin;
  logic        IncPC;
  logic        Read;
  logic [31:0] Mdatain;

  logic [31:0] busR0in, busR1in, busR2in, busR3in, busR4in, busR5in, busR6in, busR7in;
  logic [31:0] busR8in, busR9in, busR10in, busR11in, busR12in, busR13in, busR14in, busR15in;
  logic [31:0] busHIin, busLOin, busPCin, busMDRin;
  logic [31:0] Out_Port, Y, MAR, IR;
  logic        wr_ack;
  logic [4:0]  last_dest;
  logic        dest_err;

  modport master (
    output busIn,
    output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    output R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    output HIin, LOin, PCin, MDRin, Out_Portin, Yin, MARin, IRin,
    output IncPC, Read, Mdatain,
    input  busR0in, busR1in, busR2in, busR3in, busR4in, busR5in, busR6in, busR7in,
    input  busR8in, busR9in, busR10in, busR11in, busR12in, busR13in, busR14in, busR15in,
    input  busHIin, busLOin, busPCin, busMDRin,
    input  Out_Port, Y, MAR, IR,
    input  wr_ack, last_dest, dest_err
  );

  modport slave (
    input  busIn,
    input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  HIin, LOin, PCin, MDRin, Out_Portin, Yin, MARin, IRin,
    input  IncPC, Read, Mdatain,
    output busR0in, busR1in, busR2in, busR3in, busR4in, busR5in, busR6in, busR7in,
    output busR8in, busR9in, busR10in, busR11in, busR12in, busR13in, busR14in, busR15in,
    output busHIin, busLOin, busPCin, busMDRin,
    output Out_Port, Y, MAR, IR,
    output wr_ack, last_dest, dest_err
  );
endinterface

// File: rtl/bus_dest_regs.sv
// bus_dest_regs
// Destination side of the 32-bit CPU datapath bus. Loads busIn into exactly
// one of 24 destination registers per clock, selected by one-hot strobes.
// Also owns the PC increment path, the MDR memory-load path and detection
// of illegal multi-destination cycles.
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset, overrides everything else
//   bus : bus_dest_regs_if.slave -- strobes, busIn, IncPC, Read, Mdatain in;
//         register contents, wr_ack, last_dest, dest_err out
// All outputs come straight from flops; nothing combinational reaches them.
module bus_dest_regs (
  input logic           clk,
  input logic           clr,
  bus_dest_regs_if.slave bus
);

  localparam int NDEST   = 24;
  localparam int IDX_PC  = 18;
  localparam int IDX_MDR = 19;

  logic [NDEST-1:0] w_strobe;
  logic [4:0]       w_count;
  logic [4:0]       w_index;
  logic             w_legal;
  logic             w_multi;
  logic [31:0]      w_q [NDEST];

  logic             r_wr_ack;
  logic [4:0]       r_last_dest;
  logic             r_dest_err;

  assign w_strobe = {bus.IRin, bus.MARin, bus.Yin, bus.Out_Portin,
                     bus.MDRin, bus.PCin, bus.LOin, bus.HIin,
                     bus.R15in, bus.R14in, bus.R13in, bus.R12in,
                     bus.R11in, bus.R10in, bus.R9in, bus.R8in,
                     bus.R7in, bus.R6in, bus.R5in, bus.R4in,
                     bus.R3in, bus.R2in, bus.R1in, bus.R0in};

  // Population count plus index of the set strobe. The index is only
  // meaningful when exactly one strobe is high.
  always_comb begin
    w_count = '0;
    w_index = '0;
    for (int i = 0; i < NDEST; i++) begin
      if (w_strobe[i]) begin
        w_count = w_count + 5'd1;
        w_index = 5'(i);
      end
    end
  end

  assign w_legal = (w_count == 5'd1);
  assign w_multi = (w_count > 5'd1);

  genvar gi;
  generate
    for (gi = 0; gi < NDEST; gi++) begin : g_dest
      logic [31:0] r_val;
      logic [31:0] w_load_val;

      // MDR takes memory data when Read is set; every other register
      // (and MDR with Read low) takes the bus.
      if (gi == IDX_MDR) begin : g_mdr_src
        assign w_load_val = bus.Read ? bus.Mdatain : bus.busIn;
      end else begin : g_bus_src
        assign w_load_val = bus.busIn;
      end

      // PC increments whenever it is not itself loaded legally, including
      // in a conflict cycle where all bus loads are suppressed.
      if (gi == IDX_PC) begin : g_pc
        always_ff @(posedge clk) begin
          if (clr) begin
            r_val <= '0;
          end else if (w_legal && w_strobe[gi]) begin
            r_val <= w_load_val;
          end else if (bus.IncPC) begin
            r_val <= r_val + 32'd1;
          end
        end
      end else begin : g_plain
        always_ff @(posedge clk) begin
          if (clr) begin
            r_val <= '0;
          end else if (w_legal && w_strobe[gi]) begin
            r_val <= w_load_val;
          end
        end
      end

      assign w_q[gi] = r_val;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ack    <= 1'b0;
      r_last_dest <= '0;
      r_dest_err  <= 1'b0;
    end else begin
      r_wr_ack <= w_legal;
      if (w_legal) begin
        r_last_dest <= w_index;
      end
      // Sticky until clr.
      if (w_multi) begin
        r_dest_err <= 1'b1;
      end
    end
  end

  assign bus.busR0in   = w_q[0];
  assign bus.busR1in   = w_q[1];
  assign bus.busR2in   = w_q[2];
  assign bus.busR3in   = w_q[3];
  assign bus.busR4in   = w_q[4];
  assign bus.busR5in   = w_q[5];
  assign bus.busR6in   = w_q[6];
  assign bus.busR7in   = w_q[7];
  assign bus.busR8in   = w_q[8];
  assign bus.busR9in   = w_q[9];
  assign bus.busR10in  = w_q[10];
  assign bus.busR11in  = w_q[11];
  assign bus.busR12in  = w_q[12];
  assign bus.busR13in  = w_q[13];
  assign bus.busR14in  = w_q[14];
  assign bus.busR15in  = w_q[15];
  assign bus.busHIin   = w_q[16];
  assign bus.busLOin   = w_q[17];
  assign bus.busPCin   = w_q[18];
  assign bus.busMDRin  = w_q[19];
  assign bus.Out_Port  = w_q[20];
  assign bus.Y         = w_q[21];
  assign bus.MAR       = w_q[22];
  assign bus.IR        = w_q[23];

  assign bus.wr_ack    = r_wr_ack;
  assign bus.last_dest = r_last_dest;
  assign bus.dest_err  = r_dest_err;

endmodule

// File: tb/tb_bus_dest_regs.sv
// tb_bus_dest_regs
// Self-checking bench for bus_dest_regs: a table of hand-derived vectors
// covering the documented scenarios, a sweep over every destination, and a
// randomized run compared against a behavioural model of the register file.
module tb_bus_dest_regs;

  logic        clk;
  logic        clr;
  logic [23:0] strb;
  logic        inc;
  logic        rd;
  logic [31:0] bus_v;
  logic [31:0] md_v;

  int checks;
  int errors;

  bus_dest_regs_if bif ();

  bus_dest_regs dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bif.busIn      = bus_v;
  assign bif.IncPC      = inc;
  assign bif.Read       = rd;
  assign bif.Mdatain    = md_v;
  assign bif.R0in       = strb[0];
  assign bif.R1in       = strb[1];
  assign bif.R2in       = strb[2];
  assign bif.R3in       = strb[3];
  assign bif.R4in       = strb[4];
  assign bif.R5in       = strb[5];
  assign bif.R6in       = strb[6];
  assign bif.R7in       = strb[7];
  assign bif.R8in       = strb[8];
  assign bif.R9in       = strb[9];
  assign bif.R10in      = strb[10];
  assign bif.R11in      = strb[11];
  assign bif.R12in      = strb[12];
  assign bif.R13in      = strb[13];
  assign bif.R14in      = strb[14];
  assign bif.R15in      = strb[15];
  assign bif.HIin       = strb[16];
  assign bif.LOin       = strb[17];
  assign bif.PCin       = strb[18];
  assign bif.MDRin      = strb[19];
  assign bif.Out_Portin = strb[20];
  assign bif.Yin        = strb[21];
  assign bif.MARin      = strb[22];
  assign bif.IRin       = strb[23];

  wire [31:0] q [24];
  assign q[0]  = bif.busR0in;
  assign q[1]  = bif.busR1in;
  assign q[2]  = bif.busR2in;
  assign q[3]  = bif.busR3in;
  assign q[4]  = bif.busR4in;
  assign q[5]  = bif.busR5in;
  assign q[6]  = bif.busR6in;
  assign q[7]  = bif.busR7in;
  assign q[8]  = bif.busR8in;
  assign q[9]  = bif.busR9in;
  assign q[10] = bif.busR10in;
  assign q[11] = bif.busR11in;
  assign q[12] = bif.busR12in;
  assign q[13] = bif.busR13in;
  assign q[14] = bif.busR14in;
  assign q[15] = bif.busR15in;
  assign q[16] = bif.busHIin;
  assign q[17] = bif.busLOin;
  assign q[18] = bif.busPCin;
  assign q[19] = bif.busMDRin;
  assign q[20] = bif.Out_Port;
  assign q[21] = bif.Y;
  assign q[22] = bif.MAR;
  assign q[23] = bif.IR;

  // Behavioural model: plain array of register values plus status bits.
  logic [31:0] m_reg [24];
  logic        m_ack;
  logic        m_err;
  logic [4:0]  m_last;

  task automatic model_step(input logic c, input logic [23:0] s, input logic pinc,
                            input logic prd, input logic [31:0] b, input logic [31:0] md);
    int n;
    int idx;
    bit pc_loaded;
    if (c) begin
      for (int i = 0; i < 24; i++) m_reg[i] = '0;
      m_ack  = 1'b0;
      m_err  = 1'b0;
      m_last = '0;
    end else begin
      n = $countones(s);
      idx = 0;
      for (int i = 0; i < 24; i++) if (s[i]) idx = i;
      pc_loaded = (n == 1) && (idx == 18);
      if (n == 1) begin
        m_reg[idx] = (idx == 19 && prd) ? md : b;
        m_last     = 5'(idx);
      end
      m_ack = (n == 1);
      if (n >= 2) m_err = 1'b1;
      if (pinc && !pc_loaded) m_reg[18] = m_reg[18] + 32'd1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, act, exp_v);
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 24; i++)
      check($sformatf("%s reg%0d", tag, i), q[i], m_reg[i]);
    check({tag, " wr_ack"},    32'(bif.wr_ack),    32'(m_ack));
    check({tag, " dest_err"},  32'(bif.dest_err),  32'(m_err));
    check({tag, " last_dest"}, 32'(bif.last_dest), 32'(m_last));
  endtask

  // Drive one cycle away from the active edge, let the edge happen, then
  // advance the model and sample just after the edge.
  task automatic step(input logic c, input logic [23:0] s, input logic pinc,
                      input logic prd, input logic [31:0] b, input logic [31:0] md);
    @(negedge clk);
    clr = c; strb = s; inc = pinc; rd = prd; bus_v = b; md_v = md;
    @(posedge clk);
    model_step(c, s, pinc, prd, b, md);
    #1;
  endtask

  typedef struct {
    logic        c;
    logic [23:0] s;
    logic        pinc;
    logic        prd;
    logic [31:0] b;
    logic [31:0] md;
    int          ridx;
    logic [31:0] rval;
    logic        ack;
    logic        err;
    logic [4:0]  last;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic [23:0] s, input logic pinc,
                              input logic prd, input logic [31:0] b, input logic [31:0] md,
                              input int ridx, input logic [31:0] rval,
                              input logic ack, input logic err, input logic [4:0] last);
    vec_t v;
    v.c = c; v.s = s; v.pinc = pinc; v.prd = prd; v.b = b; v.md = md;
    v.ridx = ridx; v.rval = rval; v.ack = ack; v.err = err; v.last = last;
    return v;
  endfunction

  localparam logic [23:0] S_PC  = 24'(1) << 18;
  localparam logic [23:0] S_MDR = 24'(1) << 19;

  vec_t tbl [16];

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1; strb = '1; inc = 1'b1; rd = 1'b1; bus_v = '1; md_v = '1;
    for (int i = 0; i < 24; i++) m_reg[i] = 'x;
    m_ack = 1'bx; m_err = 1'bx; m_last = 'x;

    //          clr  strobes        inc rd  busIn         Mdatain      reg expect         ack err last
    tbl[0]  = mk(1, 24'hFFFFFF,     1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h0,         0, 0, 0);
    tbl[1]  = mk(0, 24'(1) << 5,    0, 0, 32'h12345678, 32'h0,        5,  32'h12345678,  1, 0, 5);
    tbl[2]  = mk(0, 24'(1) << 3,    0, 0, 32'hA5A5A5A5, 32'h0,        3,  32'hA5A5A5A5,  1, 0, 3);
    tbl[3]  = mk(0, 24'(1) << 21,   0, 0, 32'hA5A5A5A5, 32'h0,        21, 32'hA5A5A5A5,  1, 0, 21);
    tbl[4]  = mk(0, S_PC,           0, 0, 32'hFFFFFFFE, 32'h0,        18, 32'hFFFFFFFE,  1, 0, 18);
    tbl[5]  = mk(0, 24'h0,          1, 0, 32'h0,        32'h0,        18, 32'hFFFFFFFF,  0, 0, 18);
    tbl[6]  = mk(0, 24'h0,          1, 0, 32'h0,        32'h0,        18, 32'h00000000,  0, 0, 18);
    tbl[7]  = mk(0, S_PC,           1, 0, 32'h100,      32'h0,        18, 32'h100,       1, 0, 18);
    tbl[8]  = mk(0, S_MDR,          0, 1, 32'h1,        32'hCAFEF00D, 19, 32'hCAFEF00D,  1, 0, 19);
    tbl[9]  = mk(0, S_MDR,          0, 0, 32'h1,        32'hCAFEF00D, 19, 32'h1,         1, 0, 19);
    tbl[10] = mk(0, 24'h0,          0, 1, 32'h2,        32'h77,       19, 32'h1,         0, 0, 19);
    tbl[11] = mk(0, 24'h6,          1, 0, 32'h55,       32'h0,        18, 32'h101,       0, 1, 19);
    tbl[12] = mk(0, 24'h0,          0, 0, 32'h0,        32'h0,        1,  32'h0,         0, 1, 19);
    tbl[13] = mk(0, 24'(1) << 7,    0, 0, 32'h9,        32'h0,        7,  32'h9,         1, 1, 7);
    tbl[14] = mk(1, 24'h0,          0, 0, 32'h0,        32'h0,        7,  32'h0,         0, 0, 0);
    tbl[15] = mk(0, 24'(1) << 23,   1, 0, 32'hDEADBEEF, 32'h0,        23, 32'hDEADBEEF,  1, 0, 23);

    for (int t = 0; t < 16; t++) begin
      step(tbl[t].c, tbl[t].s, tbl[t].pinc, tbl[t].prd, tbl[t].b, tbl[t].md);
      check($sformatf("vec%0d reg%0d", t, tbl[t].ridx), q[tbl[t].ridx], tbl[t].rval);
      check($sformatf("vec%0d wr_ack", t),    32'(bif.wr_ack),    32'(tbl[t].ack));
      check($sformatf("vec%0d dest_err", t),  32'(bif.dest_err),  32'(tbl[t].err));
      check($sformatf("vec%0d last_dest", t), 32'(bif.last_dest), 32'(tbl[t].last));
      check_model($sformatf("vec%0d", t));
    end
    // R1 and R2 were never loaded despite the conflict cycle.
    check("conflict R1", q[1], 32'h0);
    check("conflict R2", q[2], 32'h0);

    // Clear, then load every destination once with a distinct value.
    step(1, 24'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 24; d++) begin
      step(0, 24'(1) << d, 0, 0, 32'h1000 + 32'(d), 32'h0);
      check($sformatf("sweep%0d value", d), q[d], 32'h1000 + 32'(d));
      check($sformatf("sweep%0d last", d), 32'(bif.last_dest), 32'(d));
      check_model($sformatf("sweep%0d", d));
    end
    // wr_ack must drop in the cycle after an idle edge.
    step(0, 24'h0, 0, 0, 32'h0, 32'h0);
    check("idle wr_ack", 32'(bif.wr_ack), 32'h0);

    // Load then clr on the next edge: no ack survives.
    step(0, 24'(1) << 4, 0, 0, 32'h44, 32'h0);
    step(1, 24'h0, 0, 0, 32'h0, 32'h0);
    check("clr after load wr_ack", 32'(bif.wr_ack), 32'h0);
    check_model("clr after load");

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      logic [23:0] s;
      logic        c;
      int          k;
      int          a;
      int          b2;
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 23);
      b2 = (a + $urandom_range(1, 23)) % 24;
      if (k == 0)      s = '0;
      else if (k == 1) s = (24'(1) << a) | (24'(1) << b2);
      else if (k == 2) s = 24'($urandom);
      else             s = 24'(1) << a;
      c = ($urandom_range(0, 39) == 0);
      step(c, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
